// File: rtl/ibex_pkg.sv
// ============================================================================
// Module : ibex_pkg
// Types and constants shared by the writeback result buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ibex_pkg;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_buf_entry_t;

    localparam int WbBufDepthDefault = 2;

endpackage

`default_nettype wire

// File: rtl/ibex_wb_fwd_match.sv
// ============================================================================
// Module : ibex_wb_fwd_match
// Combinational youngest-match search over the writeback buffer entries.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ibex_wb_fwd_match
    import ibex_pkg::*;
#(
    parameter  int Depth = WbBufDepthDefault,
    localparam int PtrW  = $clog2(Depth)
) (
    input  wb_buf_entry_t [Depth-1:0] entries,
    input  logic [Depth-1:0]          occupied,
    input  logic [PtrW-1:0]           wr_ptr,
    input  logic [4:0]                addr,
    output logic                      hit,
    output logic [31:0]               data
);

    logic [PtrW-1:0] idx;

    // Walk from oldest (wr_ptr-Depth) to youngest (wr_ptr-1); later matches override.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = Depth; k >= 1; k--) begin
            idx = wr_ptr - PtrW'(k);
            if (occupied[idx] && (entries[idx].addr == addr) && (addr != 5'd0)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ibex_wb_result_buffer.sv
// ============================================================================
// Module : ibex_wb_result_buffer
// In-order EX result buffer draining to the RF write port, with ID forwarding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ibex_wb_result_buffer
    import ibex_pkg::*;
#(
    parameter  int Depth = WbBufDepthDefault,
    localparam int PtrW  = $clog2(Depth),
    localparam int CntW  = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic            ex_rd_we_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic [31:0]     ex_result_i,
    input  logic            rf_grant_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [31:0]     rf_wdata_o,
    input  logic [4:0]      fwd_rs1_addr_i,
    input  logic [4:0]      fwd_rs2_addr_i,
    output logic            fwd_rs1_hit_o,
    output logic [31:0]     fwd_rs1_data_o,
    output logic            fwd_rs2_hit_o,
    output logic [31:0]     fwd_rs2_data_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o
);

    wb_buf_entry_t [Depth-1:0] entries;
    logic [PtrW-1:0]           rd_ptr;
    logic [PtrW-1:0]           wr_ptr;
    logic [CntW-1:0]           count;
    logic [Depth-1:0]          occupied;
    logic                      empty;
    logic                      push;
    logic                      pop;

    assign empty      = (count == '0);
    assign rf_we_o    = ~empty;
    assign pop        = rf_we_o & rf_grant_i;
    // Grant-to-ready is a deliberate combinational path: a draining full buffer still accepts.
    assign ex_ready_o = (count < CntW'(Depth)) | pop;
    assign push       = ex_valid_i & ex_ready_o & ex_rd_we_i & (ex_rd_addr_i != 5'd0);

    assign rf_waddr_o = empty ? 5'd0  : entries[rd_ptr].addr;
    assign rf_wdata_o = empty ? 32'd0 : entries[rd_ptr].data;
    assign count_o    = count;
    assign empty_o    = empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entries <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= '{addr: ex_rd_addr_i, data: ex_result_i};
                wr_ptr          <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot i is occupied when its distance from the head is below the count.
    for (genvar i = 0; i < Depth; i++) begin : g_occ
        logic [PtrW-1:0] offs;
        assign offs        = PtrW'(i) - rd_ptr;
        assign occupied[i] = ({1'b0, offs} < count);
    end

    ibex_wb_fwd_match #(.Depth(Depth)) u_fwd_rs1 (
        .entries  (entries),
        .occupied (occupied),
        .wr_ptr   (wr_ptr),
        .addr     (fwd_rs1_addr_i),
        .hit      (fwd_rs1_hit_o),
        .data     (fwd_rs1_data_o)
    );

    ibex_wb_fwd_match #(.Depth(Depth)) u_fwd_rs2 (
        .entries  (entries),
        .occupied (occupied),
        .wr_ptr   (wr_ptr),
        .addr     (fwd_rs2_addr_i),
        .hit      (fwd_rs2_hit_o),
        .data     (fwd_rs2_data_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_ibex_wb_result_buffer.sv
// ============================================================================
// Module : tb_ibex_wb_result_buffer
// Scoreboard bench for the writeback result buffer (Depth = 2).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ibex_wb_result_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_rd_we;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_result;
    logic        rf_grant;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_hit;
    logic [31:0] rs1_data;
    logic        rs2_hit;
    logic [31:0] rs2_data;
    logic [1:0]  count;
    logic        empty;

    int total = 0;
    int bad   = 0;

    logic [36:0] sb_q[$];

    always #5 clk = ~clk;

    ibex_wb_result_buffer #(.Depth(DEPTH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ex_valid_i     (ex_valid),
        .ex_ready_o     (ex_ready),
        .ex_rd_we_i     (ex_rd_we),
        .ex_rd_addr_i   (ex_rd_addr),
        .ex_result_i    (ex_result),
        .rf_grant_i     (rf_grant),
        .rf_we_o        (rf_we),
        .rf_waddr_o     (rf_waddr),
        .rf_wdata_o     (rf_wdata),
        .fwd_rs1_addr_i (rs1_addr),
        .fwd_rs2_addr_i (rs2_addr),
        .fwd_rs1_hit_o  (rs1_hit),
        .fwd_rs1_data_o (rs1_data),
        .fwd_rs2_hit_o  (rs2_hit),
        .fwd_rs2_data_o (rs2_data),
        .count_o        (count),
        .empty_o        (empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] model_fwd(input logic [4:0] a);
        logic [32:0] r;
        r = '0;
        for (int i = 0; i < sb_q.size(); i++) begin
            if (a != 5'd0 && sb_q[i][36:32] == a) r = {1'b1, sb_q[i][31:0]};
        end
        return r;
    endfunction

    // Compare everything observable against the queue model, then update it.
    task automatic sb_cycle();
        logic [32:0] f1, f2;
        logic        m_pop, m_ready, m_push;
        int          n;
        n       = sb_q.size();
        m_pop   = (n != 0) && rf_grant;
        m_ready = (n < DEPTH) || m_pop;
        m_push  = ex_valid && m_ready && ex_rd_we && (ex_rd_addr != 5'd0);
        f1      = model_fwd(rs1_addr);
        f2      = model_fwd(rs2_addr);
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("rf_we", 32'(rf_we), 32'(n != 0));
        check("ex_ready", 32'(ex_ready), 32'(m_ready));
        check("rs1_hit", 32'(rs1_hit), 32'(f1[32]));
        check("rs1_data", rs1_data, f1[31:0]);
        check("rs2_hit", 32'(rs2_hit), 32'(f2[32]));
        check("rs2_data", rs2_data, f2[31:0]);
        if (n != 0) begin
            check("rf_waddr", 32'(rf_waddr), 32'(sb_q[0][36:32]));
            check("rf_wdata", rf_wdata, sb_q[0][31:0]);
        end else begin
            check("rf_waddr_idle", 32'(rf_waddr), 32'd0);
            check("rf_wdata_idle", rf_wdata, 32'd0);
        end
        if (m_pop) void'(sb_q.pop_front());
        if (m_push) sb_q.push_back({ex_rd_addr, ex_result});
    endtask

    task automatic step();
        @(negedge clk);
        sb_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
        ex_valid   = v;
        ex_rd_we   = we;
        ex_rd_addr = a;
        ex_result  = d;
    endtask

    initial begin
        rst_n    = 1'b0;
        rf_grant = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        drive(1'b0, 1'b0, 5'd0, 32'd0);

        // Reset / idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_ready", 32'(ex_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        rst_n = 1'b1;
        step();

        // Single result with grant held
        rf_grant = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        check("single_we", 32'(rf_we), 32'd1);
        check("single_addr", 32'(rf_waddr), 32'd5);
        check("single_data", rf_wdata, 32'hDEADBEEF);
        step();
        check("single_empty_after", 32'(empty), 32'd1);

        // Fill and back-pressure
        rf_grant = 1'b0;
        drive(1'b1, 1'b1, 5'd1, 32'h11);
        step();
        drive(1'b1, 1'b1, 5'd2, 32'h22);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        check("full_count", 32'(count), 32'd2);
        check("full_ready", 32'(ex_ready), 32'd0);
        rf_grant = 1'b1;
        #1;
        check("grant_ready_comb", 32'(ex_ready), 32'd1);
        check("first_write_addr", 32'(rf_waddr), 32'd1);
        rf_grant = 1'b0;
        step();

        // Full plus simultaneous push/pop
        drive(1'b1, 1'b1, 5'd2, 32'h22);
        step();
        check("refill_count", 32'(count), 32'd2);
        rf_grant = 1'b1;
        drive(1'b1, 1'b1, 5'd3, 32'h33);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        check("pushpop_count", 32'(count), 32'd2);
        check("pushpop_head", 32'(rf_waddr), 32'd2);
        step();
        check("after_head", 32'(rf_waddr), 32'd3);
        step();
        step();

        // Discards on an empty buffer
        rf_grant = 1'b0;
        drive(1'b1, 1'b0, 5'd9, 32'h99);
        step();
        check("discard_we0_count", 32'(count), 32'd0);
        drive(1'b1, 1'b1, 5'd0, 32'h98);
        step();
        check("discard_r0_count", 32'(count), 32'd0);

        // Forwarding priority
        drive(1'b1, 1'b1, 5'd7, 32'hA);
        step();
        drive(1'b1, 1'b1, 5'd7, 32'hB);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        rs1_addr = 5'd7;
        rs2_addr = 5'd0;
        #1;
        check("fwd_rs1_hit", 32'(rs1_hit), 32'd1);
        check("fwd_rs1_data", rs1_data, 32'hB);
        check("fwd_rs2_zero_hit", 32'(rs2_hit), 32'd0);
        step();

        // Asynchronous reset with two entries buffered
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_rf_we", 32'(rf_we), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                  5'($urandom_range(0, 6)), $urandom);
            rf_grant = 1'($urandom_range(0, 2) != 0);
            rs1_addr = 5'($urandom_range(0, 6));
            rs2_addr = 5'($urandom_range(0, 6));
            step();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        rf_grant = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ibex_wb_result_buffer.md
# ibex_wb_result_buffer

Small in-order writeback buffer downstream of the execute block. It captures each completed EX result and its destination register, then drains results to the register-file write port whenever that port is granted; load writeback from the LSU has priority on that port. While results are buffered, it provides operand forwarding to ID so the pipeline does not stall on read-after-write hazards.

## Interface
Parameters:
- Depth, 2, number of buffer entries; legal values 2 or 4 (power of two).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- ex_valid_i  in  1  EX presents a completed result this cycle
- ex_ready_o  out  1  buffer accepts the EX result this cycle
- ex_rd_we_i  in  1  result is to be written to the register file
- ex_rd_addr_i  in  5  destination register
- ex_result_i  in  32  result value from EX
- rf_grant_i  in  1  register-file write port is free this cycle (LSU not writing)
- rf_we_o  out  1  write request for the head entry
- rf_waddr_o  out  5  head entry destination
- rf_wdata_o  out  32  head entry data
- fwd_rs1_addr_i  in  5  ID source-operand address, port 1
- fwd_rs2_addr_i  in  5  ID source-operand address, port 2
- fwd_rs1_hit_o  out  1  a buffered entry matches rs1
- fwd_rs1_data_o  out  32  forwarded rs1 value
- fwd_rs2_hit_o  out  1  a buffered entry matches rs2
- fwd_rs2_data_o  out  32  forwarded rs2 value
- count_o  out  $clog2(Depth)+1  number of occupied entries
- empty_o  out  1  count_o == 0

## Operation
- **Storage.** Circular FIFO of Depth entries, each holding {addr[4:0], data[31:0]}.
  - Pointers are rd_ptr and wr_ptr, each $clog2(Depth) bits; both wrap modulo Depth.
  - count is a separate register, $clog2(Depth)+1 bits.
- **Accept.** A transfer happens when ex_valid_i & ex_ready_o.
  - Push only if ex_rd_we_i=1 and ex_rd_addr_i≠0.
  - Otherwise the transfer is accepted and discarded: no push, no state change.
- **Drain.**
  - rf_we_o = ~empty. rf_waddr_o and rf_wdata_o carry the head entry.
  - pop = rf_we_o & rf_grant_i.
  - When empty, rf_waddr_o and rf_wdata_o are driven to 0.
- **Ready.** ex_ready_o = (count < Depth) | pop.
  - This is a combinational path from rf_grant_i; it is intentional.
- **Count update.** count_next = count + push − pop.
  - Simultaneous push and pop leaves count unchanged and advances both pointers.
  - Push at full is only possible with a same-cycle pop.
  - Pop at empty cannot occur, because rf_we_o=0.
- **Forwarding.** For each rs port, compare the address against all occupied entries.
  - Address 0 never hits.
  - On a hit, the youngest matching entry (the one closest to wr_ptr−1) supplies the data.
  - On a miss, hit=0 and data=0.
  - Forwarding reflects registered state only. A same-cycle EX result is not forwarded; EX bypasses it itself.
  - The head entry being popped this cycle still forwards (the RF read sees the old value until the next edge).
- **Ordering.** Register-file writes occur in strict acceptance order. No entry is ever overwritten before it is popped.

## Timing
- **Reset.** All state is cleared asynchronously on rst_ni=0: count=0, pointers=0, entries=0.
- **Outputs during reset:**
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0
  - ex_ready_o=1
  - fwd_*_hit_o=0, fwd_*_data_o=0
  - count_o=0, empty_o=1
- **Reset mid-operation.** Buffered results are lost. The core reset covers this.
- **Latency.** An accepted result appears on rf_* in the next cycle. With rf_grant_i held at 1, the write completes in the cycle after acceptance.
- **Throughput.** One accept and one write per cycle are sustained when rf_grant_i=1.
- **Forwarding.** An entry is visible to forwarding from the cycle after its push until the edge at which it pops.
- **Stall.** With rf_grant_i=0, the buffer fills in Depth accepts; ex_ready_o then stays 0 until rf_grant_i returns.

## Structure
- ibex_pkg holds:
  - wb_buf_entry_t, a packed struct {logic [4:0] addr; logic [31:0] data;}
  - the constant WbBufDepthDefault = 2
- Sub-module ibex_wb_fwd_match is natural: a combinational youngest-match search that takes the entry array, occupancy mask, wr_ptr and a query address. It is instantiated once per rs port.
- The top module holds the pointers, count, entry registers and handshake.

## Test plan
- **Reset/idle.** Hold rst_ni=0, then release → all outputs at their reset values; ex_ready_o=1, empty_o=1.
- **Single result.** Push rd=5, data=0xDEADBEEF with rf_grant_i=1 → next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; empty_o=1 the cycle after.
- **Fill/back-pressure (Depth=2).** rf_grant_i=0, push rd=1/0x11 then rd=2/0x22 → count_o=2 and ex_ready_o=0. Raise rf_grant_i → ex_ready_o=1 in the same cycle; writes occur in order 1 then 2.
- **Full plus simultaneous push/pop.** Full buffer, rf_grant_i=1, push rd=3/0x33 → count_o stays 2; next write is rd=2; rd=3 is written after it.
- **Forwarding priority.** Buffer holds rd=7/0xA then rd=7/0xB, fwd_rs1_addr_i=7 → fwd_rs1_hit_o=1, fwd_rs1_data_o=0xB. fwd_rs2_addr_i=0 → hit=0.
- **Discard and reset.**
  - Accept ex_rd_we_i=0 or rd=0 → accepted, count_o unchanged.
  - Assert rst_ni=0 with 2 entries buffered → count_o=0 and rf_we_o=0 immediately (asynchronous).
